// File: rtl/wdt_pkg.sv
// Shared types and register map for the multi-channel watchdog.
package wdt_pkg;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_RUN      = 2'd1,
    ST_WARN     = 2'd2,
    ST_EXPIRED  = 2'd3
  } wdt_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_TIMEOUT = 2'd1,
    CAUSE_BADKEY  = 2'd2,
    CAUSE_WINDOW  = 2'd3
  } wdt_cause_e;

  localparam logic [3:0] OFF_CTRL     = 4'd0;
  localparam logic [3:0] OFF_PRESCALE = 4'd1;
  localparam logic [3:0] OFF_TIMEOUT  = 4'd2;
  localparam logic [3:0] OFF_WARN     = 4'd3;
  localparam logic [3:0] OFF_WINDOW   = 4'd4;
  localparam logic [3:0] OFF_KICK     = 4'd5;
  localparam logic [3:0] OFF_STATUS   = 4'd6;
  localparam logic [3:0] OFF_COUNT    = 4'd7;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_WIN_EN = 1;
  localparam int CTRL_LOCK   = 2;

  localparam int STAT_CAUSE_LSB = 2;
  localparam int STAT_WARN      = 4;
  localparam int STAT_EXPIRED   = 5;

endpackage

// File: rtl/wdt_channel.sv
// One watchdog channel: config registers, prescaler, timeout counter and FSM.
module wdt_channel
  import wdt_pkg::*;
#(
  parameter int                CNT_W       = 21,
  parameter int                PRE_W       = 16,
  parameter int                DATA_W      = 21,
  parameter logic [DATA_W-1:0] KICK_KEY    = 'h0A5C3,
  parameter int                RST_PULSE   = 4,
  parameter int                DEF_TIMEOUT = 25
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              wr,
  input  logic [3:0]        off,
  input  logic [DATA_W-1:0] wdata,
  input  logic              cpu_forced_reset,
  output logic [DATA_W-1:0] rd_data,
  output logic              cpu_reset_trig,
  output logic              warn_irq
);

  localparam int PW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;

  logic             en, win_en, lock;
  logic [PRE_W-1:0] prescale, pre_cnt;
  logic [CNT_W-1:0] timeout, warn_lvl, window, cnt, cnt_inc;
  logic [PW-1:0]    pulse_cnt;
  logic             warn_flag, expired;
  wdt_state_e       state;
  wdt_cause_e       cause, exp_cause;

  logic cfg_wr, wr_ctrl, wr_kick, wr_status;
  logic running, tick, key_ok, win_bad, kick, kick_ok, expire_now;

  assign cfg_wr    = wr && !lock;
  assign wr_ctrl   = cfg_wr && (off == OFF_CTRL);
  assign wr_kick   = wr && (off == OFF_KICK);
  assign wr_status = wr && (off == OFF_STATUS);

  assign running = (state == ST_RUN) || (state == ST_WARN);
  assign tick    = (pre_cnt == prescale);
  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
  assign key_ok  = (wdata == KICK_KEY);
  assign win_bad = win_en && (cnt < window);
  assign kick    = wr_kick && running;
  assign kick_ok = kick && key_ok && !win_bad;

  // A valid kick outranks the timeout compare in the same cycle.
  always_comb begin
    expire_now = 1'b0;
    exp_cause  = CAUSE_TIMEOUT;
    if (running) begin
      if (kick && !key_ok) begin
        expire_now = 1'b1;
        exp_cause  = CAUSE_BADKEY;
      end else if (kick && win_bad) begin
        expire_now = 1'b1;
        exp_cause  = CAUSE_WINDOW;
      end else if (!kick && (cnt == timeout)) begin
        expire_now = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      en             <= 1'b0;
      win_en         <= 1'b0;
      lock           <= 1'b0;
      prescale       <= '0;
      timeout        <= CNT_W'(DEF_TIMEOUT);
      warn_lvl       <= '0;
      window         <= '0;
      pre_cnt        <= '0;
      cnt            <= '0;
      pulse_cnt      <= '0;
      warn_flag      <= 1'b0;
      expired        <= 1'b0;
      state          <= ST_DISABLED;
      cause          <= CAUSE_NONE;
      cpu_reset_trig <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en     <= wdata[CTRL_EN];
        win_en <= wdata[CTRL_WIN_EN];
        lock   <= wdata[CTRL_LOCK];
      end
      if (cfg_wr && off == OFF_PRESCALE) prescale <= wdata[PRE_W-1:0];
      if (cfg_wr && off == OFF_TIMEOUT)  timeout  <= wdata[CNT_W-1:0];
      if (cfg_wr && off == OFF_WARN)     warn_lvl <= wdata[CNT_W-1:0];
      if (cfg_wr && off == OFF_WINDOW)   window   <= wdata[CNT_W-1:0];

      if (wr_status) begin
        if (wdata[STAT_EXPIRED]) expired <= 1'b0;
        if (wdata[STAT_WARN]) begin
          warn_flag <= 1'b0;
          if (state == ST_WARN) state <= ST_RUN;
        end
        if (|wdata[STAT_CAUSE_LSB +: 2]) cause <= CAUSE_NONE;
      end

      if (wr_ctrl && !wdata[CTRL_EN]) begin
        state          <= ST_DISABLED;
        cpu_reset_trig <= 1'b0;
        pulse_cnt      <= '0;
        cnt            <= '0;
        pre_cnt        <= '0;
      end else if (wr_ctrl && state == ST_DISABLED) begin
        state   <= ST_RUN;
        cnt     <= '0;
        pre_cnt <= '0;
      end else if (cpu_forced_reset) begin
        cnt     <= '0;
        pre_cnt <= '0;
        if (state == ST_EXPIRED) begin
          state          <= ST_RUN;
          cpu_reset_trig <= 1'b0;
        end
      end else if (expire_now) begin
        state          <= ST_EXPIRED;
        cpu_reset_trig <= 1'b1;
        cause          <= exp_cause;
        expired        <= 1'b1;
        pulse_cnt      <= PW'(RST_PULSE - 1);
      end else if (kick_ok) begin
        cnt       <= '0;
        pre_cnt   <= '0;
        warn_flag <= 1'b0;
        state     <= ST_RUN;
      end else if (running) begin
        if (tick) begin
          pre_cnt <= '0;
          cnt     <= cnt_inc;
          if (warn_lvl != '0 && cnt_inc == warn_lvl) begin
            warn_flag <= 1'b1;
            state     <= ST_WARN;
          end
        end else begin
          pre_cnt <= pre_cnt + 1'b1;
        end
      end else if (state == ST_EXPIRED) begin
        if (pulse_cnt == '0) begin
          state          <= ST_RUN;
          cpu_reset_trig <= 1'b0;
          cnt            <= '0;
          pre_cnt        <= '0;
          warn_flag      <= 1'b0;
        end else begin
          pulse_cnt <= pulse_cnt - 1'b1;
        end
      end
    end
  end

  assign warn_irq = warn_flag;

  always_comb begin
    rd_data = '0;
    case (off)
      OFF_CTRL:     rd_data = DATA_W'({lock, win_en, en});
      OFF_PRESCALE: rd_data = DATA_W'(prescale);
      OFF_TIMEOUT:  rd_data = DATA_W'(timeout);
      OFF_WARN:     rd_data = DATA_W'(warn_lvl);
      OFF_WINDOW:   rd_data = DATA_W'(window);
      OFF_STATUS:   rd_data = DATA_W'({expired, warn_flag, cause, state});
      OFF_COUNT:    rd_data = DATA_W'(cnt);
      default:      rd_data = '0;
    endcase
  end

endmodule

// File: rtl/wdt_multi.sv
// Multi-channel watchdog: channel address decode, per-channel instances, read mux.
module wdt_multi
  import wdt_pkg::*;
#(
  parameter int                NUM_CH      = 2,
  parameter int                CNT_W       = 21,
  parameter int                PRE_W       = 16,
  parameter int                DATA_W      = 21,
  parameter logic [DATA_W-1:0] KICK_KEY    = 'h0A5C3,
  parameter int                RST_PULSE   = 4,
  parameter int                DEF_TIMEOUT = 25
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic [7:0]        paddr,
  input  logic [DATA_W-1:0] pwdata,
  input  logic              wren,
  input  logic              rden,
  output logic [DATA_W-1:0] prdata,
  input  logic              cpu_forced_reset,
  output logic [NUM_CH-1:0] cpu_reset_trig,
  output logic [NUM_CH-1:0] warn_irq
);

  logic [3:0]        ch_sel, reg_off;
  logic [DATA_W-1:0] ch_rd [NUM_CH];
  logic [DATA_W-1:0] rd_mux;

  assign ch_sel  = paddr[7:4];
  assign reg_off = paddr[3:0];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    wdt_channel #(
      .CNT_W      (CNT_W),
      .PRE_W      (PRE_W),
      .DATA_W     (DATA_W),
      .KICK_KEY   (KICK_KEY),
      .RST_PULSE  (RST_PULSE),
      .DEF_TIMEOUT(DEF_TIMEOUT)
    ) u_ch (
      .pclk            (pclk),
      .presetn         (presetn),
      .wr              (wren && (ch_sel == 4'(i))),
      .off             (reg_off),
      .wdata           (pwdata),
      .cpu_forced_reset(cpu_forced_reset),
      .rd_data         (ch_rd[i]),
      .cpu_reset_trig  (cpu_reset_trig[i]),
      .warn_irq        (warn_irq[i])
    );
  end

  // Channel indices with no instance never match, so they read as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == 4'(i)) rd_mux = ch_rd[i];
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)           prdata <= '0;
    else if (rden && !wren) prdata <= rd_mux;
  end

endmodule

// File: tb/tb_wdt_multi.sv
// Directed bench for wdt_multi with NUM_CH=2 and default parameters.
module tb_wdt_multi;
  localparam int DATA_W = 21;
  localparam logic [DATA_W-1:0] KEY = 21'h0A5C3;

  logic              pclk = 1'b0;
  logic              presetn = 1'b0;
  logic [7:0]        paddr = '0;
  logic [DATA_W-1:0] pwdata = '0;
  logic              wren = 1'b0;
  logic              rden = 1'b0;
  logic              cpu_forced_reset = 1'b0;
  logic [DATA_W-1:0] prdata;
  logic [1:0]        trig, warn;

  int tests = 0;
  int fails = 0;

  always #5 pclk = ~pclk;

  wdt_multi #(.NUM_CH(2)) dut (
    .pclk            (pclk),
    .presetn         (presetn),
    .paddr           (paddr),
    .pwdata          (pwdata),
    .wren            (wren),
    .rden            (rden),
    .prdata          (prdata),
    .cpu_forced_reset(cpu_forced_reset),
    .cpu_reset_trig  (trig),
    .warn_irq        (warn)
  );

  task automatic bus_write(input logic [7:0] a, input logic [DATA_W-1:0] d);
    @(negedge pclk);
    paddr = a; pwdata = d; wren = 1'b1;
    @(posedge pclk);
    #1 wren = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [DATA_W-1:0] d);
    @(negedge pclk);
    paddr = a; rden = 1'b1;
    @(posedge pclk);
    #1 rden = 1'b0;
    d = prdata;
  endtask

  task automatic apply_reset;
    presetn = 1'b0; wren = 1'b0; rden = 1'b0; cpu_forced_reset = 1'b0;
    paddr = '0; pwdata = '0;
    repeat (2) @(posedge pclk);
    @(negedge pclk) presetn = 1'b1;
  endtask

  task automatic test_reset;
    logic [DATA_W-1:0] rd;
    apply_reset();
    tests++; if (prdata !== '0) begin fails++; $display("FAIL reset_prdata: got %0h expected 0", prdata); end
    tests++; if (trig !== 2'b00) begin fails++; $display("FAIL reset_trig: got %b expected 00", trig); end
    tests++; if (warn !== 2'b00) begin fails++; $display("FAIL reset_warn: got %b expected 00", warn); end
    bus_read(8'h02, rd);
    tests++; if (rd !== 21'd25) begin fails++; $display("FAIL reset_timeout0: got %0h expected 19", rd); end
    bus_read(8'h12, rd);
    tests++; if (rd !== 21'd25) begin fails++; $display("FAIL reset_timeout1: got %0h expected 19", rd); end
    bus_read(8'h00, rd);
    tests++; if (rd !== '0) begin fails++; $display("FAIL reset_ctrl: got %0h expected 0", rd); end
    bus_read(8'h06, rd);
    tests++; if (rd !== '0) begin fails++; $display("FAIL reset_status: got %0h expected 0", rd); end
    bus_read(8'h05, rd);
    tests++; if (rd !== '0) begin fails++; $display("FAIL reset_kick_read: got %0h expected 0", rd); end
  endtask

  task automatic test_expiry;
    logic [DATA_W-1:0] rd;
    int  rise = -1;
    int  high = 0;
    bit  ch1  = 1'b0;
    apply_reset();
    bus_write(8'h00, 21'h1);
    for (int k = 1; k <= 35; k++) begin
      @(posedge pclk); #1;
      if (trig[0]) begin
        if (rise < 0) rise = k;
        high++;
      end
      if (trig[1]) ch1 = 1'b1;
    end
    tests++; if (rise != 26) begin fails++; $display("FAIL expiry_rise_edge: got %0d expected 26", rise); end
    tests++; if (high != 4) begin fails++; $display("FAIL expiry_pulse_len: got %0d expected 4", high); end
    tests++; if (ch1 !== 1'b0) begin fails++; $display("FAIL expiry_ch1_quiet: got %b expected 0", ch1); end
    bus_read(8'h06, rd);
    tests++; if (rd !== 21'h25) begin fails++; $display("FAIL expiry_status: got %0h expected 25", rd); end
  endtask

  task automatic test_warning;
    logic [DATA_W-1:0] rd;
    int rise = -1;
    apply_reset();
    bus_write(8'h11, 21'd3);
    bus_write(8'h12, 21'd10);
    bus_write(8'h13, 21'd5);
    bus_write(8'h10, 21'h1);
    for (int k = 1; k <= 24; k++) begin
      @(posedge pclk); #1;
      if (warn[1] && rise < 0) rise = k;
    end
    tests++; if (rise != 20) begin fails++; $display("FAIL warn_rise_edge: got %0d expected 20", rise); end
    tests++; if (warn[0] !== 1'b0) begin fails++; $display("FAIL warn_ch0_quiet: got %b expected 0", warn[0]); end
    bus_write(8'h15, KEY);
    tests++; if (warn[1] !== 1'b0) begin fails++; $display("FAIL warn_kick_clear: got %b expected 0", warn[1]); end
    bus_read(8'h17, rd);
    tests++; if (rd !== '0) begin fails++; $display("FAIL warn_count_after_kick: got %0h expected 0", rd); end
    bus_read(8'h16, rd);
    tests++; if (rd !== 21'h01) begin fails++; $display("FAIL warn_status_after_kick: got %0h expected 1", rd); end
  endtask

  task automatic test_keys_window;
    logic [DATA_W-1:0] rd;
    apply_reset();
    bus_write(8'h00, 21'h1);
    repeat (3) @(posedge pclk);
    bus_write(8'h05, 21'h12345);
    tests++; if (trig[0] !== 1'b1) begin fails++; $display("FAIL badkey_trig: got %b expected 1", trig[0]); end
    bus_read(8'h06, rd);
    tests++; if (rd !== 21'h2B) begin fails++; $display("FAIL badkey_status: got %0h expected 2b", rd); end
    bus_write(8'h00, 21'h0);
    tests++; if (trig[0] !== 1'b0) begin fails++; $display("FAIL disable_abort: got %b expected 0", trig[0]); end
    bus_write(8'h06, 21'h3C);
    bus_read(8'h06, rd);
    tests++; if (rd !== '0) begin fails++; $display("FAIL status_w1c: got %0h expected 0", rd); end

    bus_write(8'h04, 21'd8);
    bus_write(8'h00, 21'h3);
    repeat (4) @(posedge pclk);
    bus_write(8'h05, KEY);
    tests++; if (trig[0] !== 1'b1) begin fails++; $display("FAIL window_early_trig: got %b expected 1", trig[0]); end
    bus_read(8'h06, rd);
    tests++; if (rd !== 21'h2F) begin fails++; $display("FAIL window_status: got %0h expected 2f", rd); end

    bus_write(8'h00, 21'h0);
    bus_write(8'h06, 21'h3C);
    bus_write(8'h00, 21'h3);
    repeat (9) @(posedge pclk);
    bus_write(8'h05, KEY);
    tests++; if (trig[0] !== 1'b0) begin fails++; $display("FAIL window_ok_trig: got %b expected 0", trig[0]); end
    bus_read(8'h07, rd);
    tests++; if (rd !== '0) begin fails++; $display("FAIL window_ok_count: got %0h expected 0", rd); end
    bus_read(8'h06, rd);
    tests++; if (rd !== 21'h01) begin fails++; $display("FAIL window_ok_status: got %0h expected 1", rd); end
  endtask

  task automatic test_race;
    logic [DATA_W-1:0] rd;
    apply_reset();
    bus_write(8'h02, 21'd5);
    bus_write(8'h00, 21'h1);
    repeat (5) @(posedge pclk);
    bus_write(8'h05, KEY);
    tests++; if (trig[0] !== 1'b0) begin fails++; $display("FAIL race_trig: got %b expected 0", trig[0]); end
    bus_read(8'h07, rd);
    tests++; if (rd !== '0) begin fails++; $display("FAIL race_count: got %0h expected 0", rd); end
    bus_read(8'h06, rd);
    tests++; if (rd !== 21'h01) begin fails++; $display("FAIL race_status: got %0h expected 1", rd); end
  endtask

  task automatic test_lock;
    logic [DATA_W-1:0] rd;
    bit found = 1'b0;
    apply_reset();
    bus_write(8'h00, 21'h5);
    bus_write(8'h02, 21'd3);
    bus_read(8'h02, rd);
    tests++; if (rd !== 21'd25) begin fails++; $display("FAIL lock_timeout: got %0h expected 19", rd); end
    bus_write(8'h00, 21'h0);
    bus_read(8'h00, rd);
    tests++; if (rd !== 21'h5) begin fails++; $display("FAIL lock_ctrl: got %0h expected 5", rd); end
    for (int k = 0; k < 60 && !found; k++) begin
      @(posedge pclk); #1;
      if (trig[0]) found = 1'b1;
    end
    tests++; if (found !== 1'b1) begin fails++; $display("FAIL lock_expiry_seen: got %b expected 1", found); end
    @(posedge pclk); #3;
    presetn = 1'b0;
    #1;
    tests++; if (trig[0] !== 1'b0) begin fails++; $display("FAIL async_reset_trig: got %b expected 0", trig[0]); end
    tests++; if (prdata !== '0) begin fails++; $display("FAIL async_reset_prdata: got %0h expected 0", prdata); end
    @(negedge pclk) presetn = 1'b1;
    bus_read(8'h02, rd);
    tests++; if (rd !== 21'd25) begin fails++; $display("FAIL post_reset_timeout: got %0h expected 19", rd); end
    bus_read(8'h00, rd);
    tests++; if (rd !== '0) begin fails++; $display("FAIL post_reset_ctrl: got %0h expected 0", rd); end
  endtask

  task automatic test_forced;
    logic [DATA_W-1:0] rd;
    bit found = 1'b0;
    apply_reset();
    bus_write(8'h00, 21'h1);
    for (int k = 0; k < 40 && !found; k++) begin
      @(posedge pclk); #1;
      if (trig[0]) found = 1'b1;
    end
    tests++; if (found !== 1'b1) begin fails++; $display("FAIL forced_expiry_seen: got %b expected 1", found); end
    @(negedge pclk) cpu_forced_reset = 1'b1;
    @(posedge pclk); #1 cpu_forced_reset = 1'b0;
    tests++; if (trig[0] !== 1'b0) begin fails++; $display("FAIL forced_trig: got %b expected 0", trig[0]); end
    bus_read(8'h07, rd);
    tests++; if (rd !== '0) begin fails++; $display("FAIL forced_count: got %0h expected 0", rd); end
    bus_read(8'h06, rd);
    tests++; if (rd !== 21'h25) begin fails++; $display("FAIL forced_status: got %0h expected 25", rd); end
  endtask

  task automatic test_bus;
    logic [DATA_W-1:0] rd;
    apply_reset();
    bus_read(8'h02, rd);
    @(negedge pclk);
    paddr = 8'h04; pwdata = 21'd9; wren = 1'b1; rden = 1'b1;
    @(posedge pclk);
    #1 wren = 1'b0; rden = 1'b0;
    tests++; if (prdata !== 21'd25) begin fails++; $display("FAIL rd_wr_hold: got %0h expected 19", prdata); end
    repeat (3) @(posedge pclk);
    #1;
    tests++; if (prdata !== 21'd25) begin fails++; $display("FAIL prdata_hold: got %0h expected 19", prdata); end
    bus_read(8'h04, rd);
    tests++; if (rd !== 21'd9) begin fails++; $display("FAIL rd_wr_write_done: got %0h expected 9", rd); end
    bus_read(8'h08, rd);
    tests++; if (rd !== '0) begin fails++; $display("FAIL unmapped_offset: got %0h expected 0", rd); end
    bus_write(8'h32, 21'd7);
    bus_read(8'h12, rd);
    tests++; if (rd !== 21'd25) begin fails++; $display("FAIL ch3_write_alias: got %0h expected 19", rd); end
    bus_read(8'h52, rd);
    tests++; if (rd !== '0) begin fails++; $display("FAIL ch5_read: got %0h expected 0", rd); end
  endtask

  initial begin
    #200000;
    $display("FAIL tb_timeout: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_expiry();
    test_warning();
    test_keys_window();
    test_race();
    test_lock();
    test_forced();
    test_bus();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
